// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential RV32M-style multiply/divide unit.
// Latency: n/a (constants, types and an elaboration-time helper only).
// Backpressure: n/a.
package muldiv_seq_pkg;

   // funct3 encodings of the M-extension operations
   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Iteration counter width: must hold values 0..XLEN-1 with headroom
   function automatic int cnt_width(input int xlen);
      return $clog2(xlen) + 1;
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply/divide (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency: done XLEN+2 cycles after accept; divide-by-zero and signed overflow finish in 1 cycle.
// Backpressure: start is accepted only while busy=0; a start seen while busy is dropped, kill aborts.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = cnt_width(XLEN);

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt;
   logic [2*XLEN-1:0]   acc;      // {hi, lo}: product, or {remainder, quotient}
   logic [XLEN-1:0]     dvs;      // magnitude of op_b (multiplicand / divisor)
   logic [2:0]          op_r;
   logic                neg_r;    // final result must be negated

   // accept-time decode
   logic                a_sgn_op, b_sgn_op, sa, sb;
   logic [XLEN-1:0]     a_mag, b_mag, fast_val;
   logic                b_zero, ovf, fast, accept, last_iter;

   // shared iteration adder and sign-fix path
   logic                is_div, div_ge, sel_hi, is_mulh, fix_cin;
   logic [XLEN:0]       add_a, add_b, add_sum;
   logic [2*XLEN-1:0]   iter_nxt;
   logic [XLEN-1:0]     fix_sel, fix_val;

   // Decode the incoming request: operand magnitudes, result sign and bypass cases
   always_comb begin
      a_sgn_op  = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                  (funct3 == F_DIV)  || (funct3 == F_REM);
      b_sgn_op  = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
      sa        = a_sgn_op & op_a[XLEN-1];
      sb        = b_sgn_op & op_b[XLEN-1];
      a_mag     = sa ? (~op_a + 1'b1) : op_a;
      b_mag     = sb ? (~op_b + 1'b1) : op_b;
      b_zero    = (op_b == '0);
      ovf       = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                  (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      fast      = funct3[2] & (b_zero | ovf);
      // divide by zero: quotient all-ones, remainder = dividend; overflow: quotient = dividend, remainder 0
      if (b_zero)
         fast_val = funct3[1] ? op_a : '1;
      else
         fast_val = funct3[1] ? '0 : op_a;
      accept    = start & ~kill & ((state == ST_IDLE) || (state == ST_DONE));
      last_iter = (cnt == CW'(XLEN-1));
   end

   // One radix-2 step: shift-add for multiply, restoring subtract for divide, one shared adder
   always_comb begin
      is_div = op_r[2];
      if (is_div) begin
         add_a = {1'b0, acc[2*XLEN-2:XLEN-1]};
         add_b = {1'b1, ~dvs};
      end else begin
         add_a = {1'b0, acc[2*XLEN-1:XLEN]};
         add_b = acc[0] ? {1'b0, dvs} : '0;
      end
      add_sum = add_a + add_b + {{XLEN{1'b0}}, is_div};
      // the shifted-out remainder MSB means the partial remainder already exceeds the divisor
      div_ge  = acc[2*XLEN-1] | ~add_sum[XLEN];
      if (is_div)
         iter_nxt = {(div_ge ? add_sum[XLEN-1:0] : acc[2*XLEN-2:XLEN-1]), acc[XLEN-2:0], div_ge};
      else
         iter_nxt = {add_sum, acc[XLEN-1:1]};
   end

   // Sign correction: negate the selected half; the high half of a negated product
   // only takes the +1 carry when the low half is all zero
   always_comb begin
      is_mulh = (op_r == F_MULH) || (op_r == F_MULHSU) || (op_r == F_MULHU);
      sel_hi  = is_mulh || (op_r == F_REM) || (op_r == F_REMU);
      fix_sel = sel_hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      fix_cin = is_mulh ? (acc[XLEN-1:0] == '0) : 1'b1;
      fix_val = neg_r ? (~fix_sel + {{(XLEN-1){1'b0}}, fix_cin}) : fix_sel;
   end

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state and status outputs; kill wins over everything including a new start
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            state_nxt = ST_IDLE;
            if (accept) state_nxt = fast ? ST_DONE : ST_CALC;
            done      = (state == ST_DONE);
         end
         ST_CALC: begin
            busy = 1'b1;
            if (last_iter) state_nxt = ST_FIX;
         end
         ST_FIX: begin
            busy      = 1'b1;
            state_nxt = ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (kill) state_nxt = ST_IDLE;
   end

   // Datapath: latch on accept, iterate in CALC, commit the result in FIX or on a bypass
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc    <= '0;
         dvs    <= '0;
         op_r   <= '0;
         neg_r  <= 1'b0;
         cnt    <= '0;
         result <= '0;
      end else if (accept) begin
         op_r  <= funct3;
         neg_r <= (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
         dvs   <= b_mag;
         acc   <= {{XLEN{1'b0}}, a_mag};
         cnt   <= '0;
         if (fast) result <= fast_val;
      end else if (state == ST_CALC && !kill) begin
         acc <= iter_nxt;
         cnt <= cnt + 1'b1;
      end else if (state == ST_FIX && !kill) begin
         result <= fix_val;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq at XLEN=32.
// Latency: checks done-cycle of every op against the start cycle.
// Backpressure: exercises ignored start while busy, kill and mid-op reset.
module tb_muldiv_seq;

   localparam int XLEN = 32;

   logic            clock = 1'b0;
   logic            reset_n;
   logic            start;
   logic            kill;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   int checks = 0;
   int errors = 0;

   muldiv_seq #(.XLEN(XLEN)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .funct3  (funct3),
      .op_a    (op_a),
      .op_b    (op_b),
      .kill    (kill),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge; start is raised in cycle 0 and the
   // bench watches cycles 1..40 for the done pulse.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
      int first;
      int n;
      first  = -1;
      n      = 0;
      funct3 = f;
      op_a   = a;
      op_b   = b;
      start  = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock); #1;
         start = 1'b0;
         if (done === 1'b1) begin
            n++;
            if (first < 0) first = c;
         end
      end
      chk({tag, " done_cycle"}, first, exp_cyc);
      chk({tag, " done_count"}, n, 1);
      chk({tag, " result"}, result, exp);
   endtask

   initial begin
      int nd;
      reset_n = 1'b0;
      start   = 1'b0;
      kill    = 1'b0;
      funct3  = 3'b000;
      op_a    = '0;
      op_b    = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset busy",   busy,   0);
      chk("reset done",   done,   0);
      chk("reset result", result, 0);

      // first start on the first edge with reset released
      reset_n = 1'b1;
      run_op("MUL",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      run_op("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      run_op("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
      run_op("MULH_neg", 3'b001, 32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, 34);
      run_op("DIVU_by0", 3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
      run_op("REMU_by0", 3'b111, 32'd5,        32'd0,        32'd5,         1);
      run_op("DIV_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("REM_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
      run_op("DIV",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34);
      run_op("REM",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34);
      run_op("DIVU",   3'b101, 32'd100,      32'd7,        32'd14,        34);
      run_op("REMU",   3'b111, 32'd100,      32'd7,        32'd2,         34);

      // kill in cycle 10 of a DIV; a start in cycle 5 must be ignored
      nd     = 0;
      funct3 = 3'b100;
      op_a   = 32'hFFFF_FFF9;
      op_b   = 32'd2;
      start  = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clock); #1;
         start = (c == 5);
         kill  = (c == 10);
         if (c == 5) begin
            funct3 = 3'b101;
            op_a   = 32'd5;
            op_b   = 32'd0;
         end
         if (c == 10) chk("kill busy_c10", busy, 1);
         if (c == 11) chk("kill busy_c11", busy, 0);
         if (done === 1'b1) nd++;
      end
      kill = 1'b0;
      chk("kill no_done", nd, 0);
      chk("kill result_held", result, 32'd2);

      // kill overrides a same-cycle start
      funct3 = 3'b101;
      op_a   = 32'd5;
      op_b   = 32'd0;
      start  = 1'b1;
      kill   = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      kill  = 1'b0;
      chk("kill_start busy", busy, 0);
      chk("kill_start done", done, 0);
      chk("kill_start result", result, 32'd2);

      // asynchronous reset in cycle 20 of a MUL
      nd     = 0;
      funct3 = 3'b000;
      op_a   = 32'd7;
      op_b   = 32'hFFFF_FFFD;
      start  = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clock); #1;
         start = 1'b0;
      end
      chk("rst busy_before", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("rst busy",   busy,   0);
      chk("rst done",   done,   0);
      chk("rst result", result, 0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock); #1;
         if (done === 1'b1) nd++;
      end
      chk("rst no_done", nd, 0);
      chk("rst result_after", result, 0);
      run_op("MUL_after_rst", 3'b000, 32'd3, 32'd5, 32'd15, 34);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
